// File: rtl/bit_deframer_pkg.sv
// ---------------------------------------------------------------------------
// bit_deframer_pkg
// Shared definitions for the serial bit deframer: the FSM state encoding and
// the default frame geometry (sync word, sync width, payload width).
// No ports; imported by bit_deframer and sync_detect.
// ---------------------------------------------------------------------------
package bit_deframer_pkg;

  // Receiver state: hunting for sync, collecting payload, checking parity
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int                    DEF_SYNC_W = 4;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC   = 4'b1011;
  localparam int                    DEF_DATA_W = 8;

endpackage

// File: rtl/bit_deframer_sync_detect.sv
// ---------------------------------------------------------------------------
// sync_detect
// Sliding-window sync word matcher used while the deframer hunts for the
// start of a frame. Keeps the recent bit history and a saturating count of
// bits seen since the last clear, and flags a match combinationally on the
// edge that samples the final sync bit.
//
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-high reset
//   enable  in  high while hunting; history and count only advance then
//   clear   in  synchronous clear of history and count (end of a frame)
//   sig_in  in  serial input bit
//   match   out combinational: current window equals SYNC and enough real
//               bits have been seen to fill the window
// ---------------------------------------------------------------------------
module sync_detect
  import bit_deframer_pkg::*;
#(
  parameter int                SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = DEF_SYNC
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic sig_in,
  output logic match
);

  localparam int               CNT_W   = (SYNC_W > 2) ? $clog2(SYNC_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_W - 1);

  // The comparison window is the stored history plus the bit arriving on
  // this edge, so only SYNC_W-1 older bits ever need to be remembered; the
  // oldest bit of the window would otherwise be stored and never read.
  logic [SYNC_W-2:0] hunt_sr;
  logic [CNT_W-1:0]  hunt_cnt;
  logic [SYNC_W-1:0] window;

  assign window = {hunt_sr, sig_in};

  // The count saturates once SYNC_W-1 bits are in the history, which is the
  // point where the window first holds SYNC_W genuine bits. Until then the
  // zero-filled history cannot produce a match, even for an all-zero SYNC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hunt_sr  <= '0;
      hunt_cnt <= '0;
    end else if (clear) begin
      hunt_sr  <= '0;
      hunt_cnt <= '0;
    end else if (enable) begin
      hunt_sr <= window[SYNC_W-2:0];
      if (hunt_cnt != CNT_MAX) begin
        hunt_cnt <= hunt_cnt + 1'b1;
      end
    end
  end

  assign match = enable && (hunt_cnt >= CNT_MAX) && (window == SYNC);

endmodule

// File: rtl/bit_deframer.sv
// ---------------------------------------------------------------------------
// bit_deframer
// Recovers fixed-length frames from a filtered serial bit stream. A frame is
// the sync word (MSB first), DATA_W payload bits (LSB first) and one even
// parity bit. Good frames update data_out with a one-cycle data_valid pulse;
// bad parity gives a one-cycle parity_err pulse and leaves data_out alone.
//
// Ports:
//   clock       in  rising-edge clock
//   reset       in  asynchronous active-high reset
//   sig_in      in  serial stream, one bit per rising edge
//   data_out    out last payload that passed the parity check
//   data_valid  out one-cycle pulse when data_out is updated
//   parity_err  out one-cycle pulse when a frame fails parity
//   busy        out high while a frame is being received
// ---------------------------------------------------------------------------
module bit_deframer
  import bit_deframer_pkg::*;
#(
  parameter int                SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = DEF_SYNC,
  parameter int                DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sig_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy
);

  localparam int               BIT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            state;
  state_t            state_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] payload;
  logic              hunting;
  logic              sync_match;
  logic              hunt_clear;
  logic              parity_ok;
  logic              valid_next;
  logic              err_next;

  assign hunting = (state == HUNT);
  assign busy    = !hunting;

  sync_detect #(
    .SYNC_W (SYNC_W),
    .SYNC   (SYNC)
  ) u_sync_detect (
    .clock  (clock),
    .reset  (reset),
    .enable (hunting),
    .clear  (hunt_clear),
    .sig_in (sig_in),
    .match  (sync_match)
  );

  // Even parity over payload plus the parity bit arriving on this edge
  assign parity_ok = ~(^{payload, sig_in});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Leaving PARITY also wipes the sync history, so the tail of a completed
  // frame can never combine with new bits into a false sync match.
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    err_next   = 1'b0;
    hunt_clear = 1'b0;
    case (state)
      HUNT: begin
        if (sync_match) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          state_next = PARITY;
        end
      end
      PARITY: begin
        state_next = HUNT;
        hunt_clear = 1'b1;
        if (parity_ok) begin
          valid_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  // The bit counter is held at zero throughout HUNT, so it is already zero
  // on the first payload edge after a sync match.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      payload    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_valid <= valid_next;
      parity_err <= err_next;
      if (valid_next) begin
        data_out <= payload;
      end
      if (state == DATA) begin
        payload[bit_cnt] <= sig_in;
        bit_cnt          <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
    end
  end

endmodule
